// File: rtl/cordic_rv_pipe.sv
// cordic_rv_pipe
//   Fully pipelined CORDIC engine with valid/ready streaming and a global stall.
//   Each sample carries its own mode bit:
//     rotation  (in_mode=0): out_x = cos(in_phase), out_y = sin(in_phase), out_z = residual angle
//     vectoring (in_mode=1): out_x = |(in_x,in_y)| * CORDIC gain, out_y = residual y,
//                            out_z = atan2(in_y,in_x) modulo 2^PW
//   Pipeline: input register (stage 0), STAGES micro-rotation registers, output register.
//   The whole pipe advances only when enable && (!out_valid || out_ready).
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low; clears every register
//   enable     0 = synchronous clear of all valids and outputs
//   in_valid   input sample valid
//   in_ready   input accepted when in_valid && in_ready
//   in_mode    0 = rotation, 1 = vectoring
//   in_phase   rotation angle, full circle = 2^PW
//   in_x/in_y  vectoring operands, signed Q(DW-2)
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accept
//   out_mode   mode of the sample on the outputs
//   out_x/y/z  results (see above); x/y saturated to DW bits
module cordic_rv_pipe #(
    parameter int DW     = 16,
    parameter int PW     = 32,
    parameter int STAGES = 16,
    parameter int AMP    = 9949
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [PW-1:0]        in_phase,
    input  logic signed [DW-1:0] in_x,
    input  logic signed [DW-1:0] in_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_mode,
    output logic signed [DW-1:0] out_x,
    output logic signed [DW-1:0] out_y,
    output logic [PW-1:0]        out_z
);

    // Two guard bits absorb the CORDIC gain (~1.647) and the negated most-negative input.
    localparam int XW = DW + 2;

    // round(atan(2^-i) / (2*pi) * 2^32), i = 0..31
    localparam logic [31:0] ATAN_TAB [0:31] = '{
        32'd536870912, 32'd316933405, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    localparam logic signed [XW-1:0] AMP_X = XW'(AMP);

    function automatic logic signed [PW-1:0] atan_step(input int i);
        logic [31:0] t;
        t = ATAN_TAB[i[4:0]] >> (32 - PW);
        return PW'(t);
    endfunction

    // Clamp the internal value into the DW-bit output range.
    function automatic logic signed [DW-1:0] sat(input logic signed [XW-1:0] v);
        if (~|v[XW-1:DW-1] || &v[XW-1:DW-1])
            return v[DW-1:0];
        else if (v[XW-1])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

    logic                 advance;
    logic signed [XW-1:0] x_ext, y_ext;
    logic signed [XW-1:0] x_pre, y_pre;
    logic signed [PW-1:0] z_pre;

    logic [STAGES:0]      vld_p;
    logic [STAGES:0]      mode_p;
    logic signed [XW-1:0] x_p [0:STAGES];
    logic signed [XW-1:0] y_p [0:STAGES];
    logic signed [PW-1:0] z_p [0:STAGES];

    logic signed [XW-1:0] x_nx [0:STAGES-1];
    logic signed [XW-1:0] y_nx [0:STAGES-1];
    logic signed [PW-1:0] z_nx [0:STAGES-1];

    assign advance  = enable && (!out_valid || out_ready);
    assign in_ready = advance;

    assign x_ext = XW'(in_x);
    assign y_ext = XW'(in_y);

    // Stage 0 input: pre-rotation into the +-90 degree convergence range.
    always_comb begin
        x_pre = '0;
        y_pre = '0;
        z_pre = '0;
        if (in_mode) begin
            // Left half-plane: rotate by 180 degrees and start the angle at 2^(PW-1).
            if (in_x[DW-1]) begin
                x_pre = -x_ext;
                y_pre = -y_ext;
                z_pre = {1'b1, {(PW-1){1'b0}}};
            end else begin
                x_pre = x_ext;
                y_pre = y_ext;
            end
        end else begin
            // Quadrant selects the start vector; the remaining angle is always in [0, 90).
            case (in_phase[PW-1 -: 2])
                2'd0:    x_pre = AMP_X;
                2'd1:    y_pre = AMP_X;
                2'd2:    x_pre = -AMP_X;
                default: y_pre = -AMP_X;
            endcase
            z_pre = {2'b00, in_phase[PW-3:0]};
        end
    end

    // Stages 1..STAGES: micro-rotation i maps register i to register i+1.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            // d = +1: rotation drives z toward 0, vectoring drives y toward 0.
            if (mode_p[i] ? y_p[i][XW-1] : !z_p[i][PW-1]) begin
                x_nx[i] = x_p[i] - (y_p[i] >>> i);
                y_nx[i] = y_p[i] + (x_p[i] >>> i);
                z_nx[i] = z_p[i] - atan_step(i);
            end else begin
                x_nx[i] = x_p[i] + (y_p[i] >>> i);
                y_nx[i] = y_p[i] - (x_p[i] >>> i);
                z_nx[i] = z_p[i] + atan_step(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p  <= '0;
            mode_p <= '0;
            for (int i = 0; i <= STAGES; i++) begin
                x_p[i] <= '0;
                y_p[i] <= '0;
                z_p[i] <= '0;
            end
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
        end else if (!enable) begin
            // In-flight samples are dropped; their data words are harmless without a valid.
            vld_p     <= '0;
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
        end else if (advance) begin
            // Stage 0
            vld_p[0]  <= in_valid;
            mode_p[0] <= in_mode;
            x_p[0]    <= x_pre;
            y_p[0]    <= y_pre;
            z_p[0]    <= z_pre;
            // Stages 1..STAGES
            for (int i = 0; i < STAGES; i++) begin
                vld_p[i+1]  <= vld_p[i];
                mode_p[i+1] <= mode_p[i];
                x_p[i+1]    <= x_nx[i];
                y_p[i+1]    <= y_nx[i];
                z_p[i+1]    <= z_nx[i];
            end
            // Output register: bubbles leave zeroed outputs behind.
            out_valid <= vld_p[STAGES];
            if (vld_p[STAGES]) begin
                out_mode <= mode_p[STAGES];
                out_x    <= sat(x_p[STAGES]);
                out_y    <= sat(y_p[STAGES]);
                out_z    <= z_p[STAGES];
            end else begin
                out_mode <= 1'b0;
                out_x    <= '0;
                out_y    <= '0;
                out_z    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_rv_pipe.sv
// tb_cordic_rv_pipe
//   Bench for cordic_rv_pipe (DW=16, PW=32, STAGES=16): directed table of known
//   angles/vectors, randomized mixed-mode stream with random back-pressure checked
//   against a trigonometric reference model, enable drop and mid-stream reset.
module tb_cordic_rv_pipe;

    localparam int     DW     = 16;
    localparam int     PW     = 32;
    localparam int     STAGES = 16;
    localparam int     AMP    = 9949;
    localparam int     LAT    = STAGES + 2;
    localparam real    TWO_PI = 6.283185307179586;
    localparam real    FULL   = 4294967296.0;
    localparam real    GAIN   = 1.64676;
    localparam int     TOL_XY = 8;
    localparam longint TOL_Z  = 131072;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 enable = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_mode = 1'b0;
    logic [PW-1:0]        in_phase = '0;
    logic signed [DW-1:0] in_x = '0;
    logic signed [DW-1:0] in_y = '0;
    logic                 out_ready = 1'b0;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_mode;
    logic signed [DW-1:0] out_x;
    logic signed [DW-1:0] out_y;
    logic [PW-1:0]        out_z;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          mode;
        logic [31:0] phase;
        int          x;
        int          y;
    } samp_t;

    typedef struct {
        samp_t       s;
        int          ex;
        int          ey;
        logic [31:0] ez;
    } vec_t;

    cordic_rv_pipe #(.DW(DW), .PW(PW), .STAGES(STAGES), .AMP(AMP)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_phase  (in_phase),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic samp_t mks(input bit m, input logic [31:0] ph, input int x, input int y);
        samp_t s;
        s.mode = m; s.phase = ph; s.x = x; s.y = y;
        return s;
    endfunction

    function automatic vec_t mkv(input bit m, input logic [31:0] ph, input int x, input int y,
                                 input int ex, input int ey, input logic [31:0] ez);
        vec_t v;
        v.s = mks(m, ph, x, y); v.ex = ex; v.ey = ey; v.ez = ez;
        return v;
    endfunction

    // Reference: ideal trigonometry on the sample, scaled to the output formats.
    function automatic void model(input samp_t s, output int ex, output int ey,
                                  output logic [31:0] ez, output longint ztol);
        real    a, m, u;
        longint t;
        if (!s.mode) begin
            a  = TWO_PI * real'(s.phase) / FULL;
            ex = clamp16(int'(16384.0 * $cos(a)));
            ey = clamp16(int'(16384.0 * $sin(a)));
            ez = 32'h0;
            ztol = TOL_Z;
        end else begin
            m  = $sqrt(real'(s.x * s.x + s.y * s.y));
            ex = clamp16(int'(GAIN * m));
            ey = 0;
            a  = $atan2(real'(s.y), real'(s.x));
            if (a < 0.0) a = a + TWO_PI;
            u  = a / TWO_PI * FULL;
            t  = longint'(u);
            ez = t[31:0];
            // An 8 LSB error perpendicular to the output vector, expressed as an angle.
            ztol = TOL_Z + longint'(8.0 / (GAIN * m) / TWO_PI * FULL);
        end
    endfunction

    function automatic samp_t rand_samp();
        samp_t s;
        real   th, m;
        s.mode  = 1'($urandom_range(0, 1));
        s.phase = $urandom();
        th      = TWO_PI * real'($urandom_range(0, 65535)) / 65536.0;
        m       = real'($urandom_range(12000, 19500));
        s.x     = int'(m * $cos(th));
        s.y     = int'(m * $sin(th));
        return s;
    endfunction

    task automatic drive(input samp_t s);
        in_mode  = s.mode;
        in_phase = s.phase;
        in_x     = 16'(s.x);
        in_y     = 16'(s.y);
    endtask

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input bit emode, input int ex, input int ey,
                             input logic [31:0] ez, input longint ztol);
        longint dz;
        bit     ok;
        dz = longint'($signed(out_z - ez));
        ok = out_valid && (out_mode == emode) &&
             (labs(longint'(out_x) - ex) <= TOL_XY) &&
             (labs(longint'(out_y) - ey) <= TOL_XY) &&
             (labs(dz) <= ztol);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got valid=%0b mode=%0b x=%0d y=%0d z=%h, expected valid=1 mode=%0b x=%0d y=%0d (+-%0d) z=%h (+-%0d)",
                     name, out_valid, out_mode, out_x, out_y, out_z, emode, ex, ey, TOL_XY, ez, ztol);
        end
    endtask

    // One sample through an otherwise empty pipe; checks acceptance, latency and value.
    task automatic run_single(input string name, input vec_t v);
        int lat;
        @(negedge clk);
        drive(v.s);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq({name, "_ready"}, longint'(in_ready), 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq({name, "_latency"}, lat, LAT);
        check_out(name, v.s.mode, v.ex, v.ey, v.ez, TOL_Z);
    endtask

    // Back-to-back random stream with random back-pressure, in-order scoreboard.
    task automatic stream_test(input int n);
        samp_t                q[$];
        samp_t                cur, exp_s;
        int                   sent, got, cyc, ex, ey, extra;
        logic [31:0]          ez;
        longint               zt;
        bit                   held;
        logic                 hm;
        logic signed [DW-1:0] hx, hy;
        logic [PW-1:0]        hz;
        sent = 0; got = 0; cyc = 0; held = 1'b0;
        hm = 1'b0; hx = '0; hy = '0; hz = '0;
        cur = rand_samp();
        while ((sent < n || got < n) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                checks++;
                if (!out_valid || out_mode != hm || out_x != hx || out_y != hy || out_z != hz) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b m=%0b x=%0d y=%0d z=%h, held m=%0b x=%0d y=%0d z=%h",
                             out_valid, out_mode, out_x, out_y, out_z, hm, hx, hy, hz);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < n);
            if (sent < n) drive(cur);
            #1;
            check_eq("in_ready_rule", longint'(in_ready), longint'(enable && (!out_valid || out_ready)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_eq("stream_unexpected_output", 1, 0);
                end else begin
                    exp_s = q.pop_front();
                    model(exp_s, ex, ey, ez, zt);
                    check_out($sformatf("stream%0d", got), exp_s.mode, ex, ey, ez, zt);
                end
                got++;
            end
            held = out_valid && !out_ready;
            hm = out_mode; hx = out_x; hy = out_y; hz = out_z;
            if (in_valid && in_ready) begin
                q.push_back(cur);
                sent++;
                cur = rand_samp();
            end
        end
        in_valid = 1'b0;
        check_eq("stream_received", got, n);
        check_eq("stream_pending", q.size(), 0);
        extra = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check_eq("stream_no_duplicates", extra, 0);
    endtask

    vec_t tab [0:11];

    initial begin
        int stale;

        tab[0]  = mkv(1'b0, 32'h0000_0000,      0,      0,  16384,      0, 32'h0000_0000);
        tab[1]  = mkv(1'b0, 32'h4000_0000,      0,      0,      0,  16384, 32'h0000_0000);
        tab[2]  = mkv(1'b0, 32'h8000_0000,      0,      0, -16384,      0, 32'h0000_0000);
        tab[3]  = mkv(1'b0, 32'h2000_0000,      0,      0,  11585,  11585, 32'h0000_0000);
        tab[4]  = mkv(1'b0, 32'hE000_0000,      0,      0,  11585, -11585, 32'h0000_0000);
        tab[5]  = mkv(1'b0, 32'hFFFF_FFFF,   1234,  -999,  16384,      0, 32'h0000_0000);
        tab[6]  = mkv(1'b0, 32'hC000_0000,      0,      0,      0, -16384, 32'h0000_0000);
        tab[7]  = mkv(1'b0, 32'h6000_0000,      0,      0, -11585,  11585, 32'h0000_0000);
        tab[8]  = mkv(1'b1, 32'h1234_5678,   8192,   8192,  19078,      0, 32'h2000_0000);
        tab[9]  = mkv(1'b1, 32'h0000_0000,  -8192,      0,  13490,      0, 32'h8000_0000);
        tab[10] = mkv(1'b1, 32'h0000_0000,      0,  10000,  16468,      0, 32'h4000_0000);
        tab[11] = mkv(1'b1, 32'h0000_0000,  10000, -10000,  23289,      0, 32'hE000_0000);

        // Reset state
        #1 rst = 1'b0;
        #2;
        check_eq("reset_out_valid", longint'(out_valid), 0);
        check_eq("reset_out_mode",  longint'(out_mode), 0);
        check_eq("reset_out_x",     longint'(out_x), 0);
        check_eq("reset_out_y",     longint'(out_y), 0);
        check_eq("reset_out_z",     longint'(out_z), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b1;

        // Directed angles and vectors
        for (int i = 0; i < 12; i++) begin
            run_single($sformatf("table%0d", i), tab[i]);
        end

        // Randomized mixed-mode stream with back-pressure
        stream_test(50);

        // enable dropped with a full pipe
        out_ready = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            drive(rand_samp());
            in_valid = 1'b1;
        end
        @(negedge clk);
        check_eq("predrop_out_valid", longint'(out_valid), 1);
        enable   = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("disabled_in_ready", longint'(in_ready), 0);
        @(negedge clk);
        check_eq("drop_out_valid", longint'(out_valid), 0);
        check_eq("drop_out_x",     longint'(out_x), 0);
        check_eq("drop_out_y",     longint'(out_y), 0);
        check_eq("drop_out_z",     longint'(out_z), 0);
        check_eq("drop_out_mode",  longint'(out_mode), 0);
        enable = 1'b1;
        stale = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_eq("drop_no_stale", stale, 0);

        // rst pulsed mid-stream
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            drive(rand_samp());
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("prereset_out_valid", longint'(out_valid), 1);
        #2 rst = 1'b0;
        #1;
        check_eq("async_reset_zero", longint'({out_valid, out_mode, out_x, out_y, out_z}), 0);
        @(negedge clk);
        rst = 1'b1;
        run_single("post_reset", tab[3]);
        stale = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k > 0 && out_valid) stale++;
        end
        check_eq("post_reset_no_stale", stale, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
